fas_fft_frame_reader: RTL and testbench
=======================================

Name: fas_fft_frame_reader

Overview:
- Receive end of the FAS FFT output interface: captures one 16-bin frame presented in parallel on a single fft_valid pulse.
- Drains the frame as a serial valid/ready stream of 32-bit {real, imag} words, bin 0 first.
- Tracks the bin with the largest magnitude and reports it as peak_freq with a one-cycle frame_done pulse.
- Sits between the FAS core and the downstream analysis/host logic.

Parameters:
- DW, 16, width of each real/imag component (two's complement, 8.8 fixed point).
- DROPW, 8, width of the saturating dropped-frame counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- fft_valid  in  1  one-cycle pulse; fft_bus holds a complete frame.
- fft_bus  in  16*2*DW  bin k at [k*2*DW +: 2*DW]; real in the upper DW bits, imag in the lower DW bits.
- out_valid  out  1  out_data/out_idx hold a valid word.
- out_ready  in  1  downstream accepts the word.
- out_data  out  2*DW  {real, imag} of the current bin.
- out_idx  out  4  bin index of out_data.
- frame_done  out  1  one-cycle pulse after the last bin transfers.
- peak_freq  out  4  index of the max-magnitude bin of the last completed frame.
- drop_cnt  out  DROPW  count of frames lost while busy; saturates at all-ones.

Behaviour:
- Reset (rst=1 at a rising edge): state IDLE, out_valid=0, out_data=0, out_idx=0, frame_done=0, peak_freq=0, drop_cnt=0, buffer contents don't-care. Reset overrides everything, including mid-drain; a partial frame is discarded with no frame_done.
- States:
  - IDLE: fft_valid=1 -> latch all 16 bins into the buffer, clear the running max, idx=0, go to DRAIN. out_valid rises the next cycle, so there is one cycle of latency from fft_valid.
  - DRAIN: out_valid=1, out_data=buf[idx], out_idx=idx. A handshake is out_valid & out_ready.
  - Each handshake: compute mag(buf[idx]). If mag > running max (strict) or idx==0, load the max and max_idx. Tie keeps the lower index. Then idx+1.
  - Handshake at idx=15: register peak_freq (including the bin-15 compare) and pulse frame_done the next cycle. Next state is IDLE, unless fft_valid is also high in that same cycle: then capture the new frame and stay in DRAIN with idx=0. No frame_done is lost.
- Stalls: out_ready=0 holds out_data/out_idx stable; out_valid never drops mid-frame.
- fft_valid in DRAIN other than on the final handshake: frame dropped, drop_cnt+1 (saturating), current drain unaffected.
- Magnitude (default): |re|+|im|.
  - abs computed in DW+1 bits so -32768 maps to 32768 with no wrap.
  - Sum is DW+2 bits, unsigned compare.
- peak_freq holds its value until the next frame completes.
- frame_done is never asserted together with a state change caused by reset.

Optional Feature:
- Macro FAS_PEAK_SQMAG_EN.
- Defined: mag = re*re + im*im, signed multiply, 2*DW+1-bit unsigned result. Compare rule, tie rule and latency are unchanged; the compare stays single-cycle per handshake.
- Undefined: |re|+|im| as above, no multipliers inferred.

Test Plan:
- Single frame, bin k = {k*16, 0}, out_ready=1 throughout -> out_valid from the cycle after fft_valid for 16 consecutive cycles; out_idx 0..15; out_data[k]=k*16<<16; frame_done one cycle after idx 15; peak_freq=15.
- Backpressure: out_ready toggling 1,0,0,1 repeating, bin 3 = {0x0400, 0xFC00}, others 0x0001_0001 -> data stable during stalls; all 16 words in order; peak_freq=3.
- Ties and extremes: bin 2 = {0x8000, 0}, bin 9 = {0, 0x8000}, others 0 -> peak_freq=2 (no abs wrap, lower index wins); with FAS_PEAK_SQMAG_EN also 2.
- Overlap: second fft_valid at drain idx=5 -> drop_cnt=1, first frame completes intact. Third fft_valid coincident with the idx-15 handshake -> frame_done pulses and the next cycle restarts out_idx=0 with the new frame data.
- Reset mid-drain at idx=7 -> next cycle out_valid=0, frame_done=0, peak_freq=0, drop_cnt=0; a following frame drains normally from idx 0.
- Saturation: 300 fft_valid pulses while out_ready=0 -> drop_cnt=255 and holds.

Source files
------------

// File: rtl/fas_fft_frame_reader.sv
// Captures a 16-bin FFT frame in one cycle, drains it as a serial valid/ready stream and reports the peak bin.
// Optional FAS_PEAK_SQMAG_EN selects re^2+im^2 magnitude instead of |re|+|im|.
module fas_fft_frame_reader #(
    parameter int DW    = 16,
    parameter int DROPW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 fft_valid,
    input  logic [16*2*DW-1:0]   fft_bus,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*DW-1:0]      out_data,
    output logic [3:0]           out_idx,
    output logic                 frame_done,
    output logic [3:0]           peak_freq,
    output logic [DROPW-1:0]     drop_cnt
);

    typedef enum logic {IDLE, DRAIN} state_t;

`ifdef FAS_PEAK_SQMAG_EN
    localparam int MW = 2*DW+1;
`else
    localparam int MW = DW+2;
`endif

    state_t              state_q, state_d;
    logic [2*DW-1:0]     buf_q [16];
    logic [2*DW-1:0]     buf_d [16];
    logic [3:0]          idx_q, idx_d;
    logic [MW-1:0]       max_q, max_d;
    logic [3:0]          max_idx_q, max_idx_d;
    logic [3:0]          peak_q, peak_d;
    logic                done_q, done_d;
    logic [DROPW-1:0]    drop_q, drop_d;

    logic [2*DW-1:0]     cur;
    logic [DW-1:0]       re, im;
    logic [MW-1:0]       mag;
    logic                hs, last, better;

    assign cur = buf_q[idx_q];
    assign re  = cur[2*DW-1:DW];
    assign im  = cur[DW-1:0];

`ifdef FAS_PEAK_SQMAG_EN
    logic signed [DW-1:0]   re_s, im_s;
    logic signed [2*DW-1:0] re_sq, im_sq;

    always_comb begin
        re_s  = re;
        im_s  = im;
        re_sq = re_s * re_s;
        im_sq = im_s * im_s;
        mag   = {1'b0, re_sq} + {1'b0, im_sq};
    end
`else
    // Extend by one bit before negating so the most negative value has a representable magnitude.
    logic signed [DW:0] re_x, im_x;
    logic        [DW:0] re_abs, im_abs;

    always_comb begin
        re_x   = {re[DW-1], re};
        im_x   = {im[DW-1], im};
        re_abs = re_x[DW] ? -re_x : re_x;
        im_abs = im_x[DW] ? -im_x : im_x;
        mag    = {1'b0, re_abs} + {1'b0, im_abs};
    end
`endif

    assign hs     = (state_q == DRAIN) && out_ready;
    assign last   = hs && (idx_q == 4'd15);
    assign better = (mag > max_q) || (idx_q == 4'd0);

    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        idx_d     = idx_q;
        max_d     = max_q;
        max_idx_d = max_idx_q;
        peak_d    = peak_q;
        done_d    = 1'b0;
        drop_d    = drop_q;

        case (state_q)
            IDLE: begin
                if (fft_valid) begin
                    for (int k = 0; k < 16; k++) begin
                        buf_d[k] = fft_bus[k*2*DW +: 2*DW];
                    end
                    max_d   = '0;
                    idx_d   = 4'd0;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (hs) begin
                    if (better) begin
                        max_d     = mag;
                        max_idx_d = idx_q;
                    end
                    idx_d = idx_q + 4'd1;
                end
                if (last) begin
                    peak_d = better ? idx_q : max_idx_q;
                    done_d = 1'b1;
                    // A frame arriving on the final handshake is taken directly rather than dropped.
                    if (fft_valid) begin
                        for (int k = 0; k < 16; k++) begin
                            buf_d[k] = fft_bus[k*2*DW +: 2*DW];
                        end
                        max_d = '0;
                        idx_d = 4'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (fft_valid && (drop_q != {DROPW{1'b1}})) begin
                    drop_d = drop_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            max_q     <= '0;
            max_idx_q <= 4'd0;
            peak_q    <= 4'd0;
            done_q    <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            max_q     <= max_d;
            max_idx_q <= max_idx_d;
            peak_q    <= peak_d;
            done_q    <= done_d;
            drop_q    <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign out_valid  = (state_q == DRAIN);
    assign out_data   = out_valid ? cur : '0;
    assign out_idx    = idx_q;
    assign frame_done = done_q;
    assign peak_freq  = peak_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_fas_fft_frame_reader.sv
// Scoreboard bench for fas_fft_frame_reader: expected words and peaks are queued at stimulus time.
module tb_fas_fft_frame_reader;

    localparam int DW    = 16;
    localparam int DROPW = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              fft_valid;
    logic [16*2*DW-1:0] fft_bus;
    logic              out_valid;
    logic              out_ready;
    logic [2*DW-1:0]   out_data;
    logic [3:0]        out_idx;
    logic              frame_done;
    logic [3:0]        peak_freq;
    logic [DROPW-1:0]  drop_cnt;

    always #5 clk = ~clk;

    fas_fft_frame_reader #(.DW(DW), .DROPW(DROPW)) dut (
        .clk        (clk),
        .rst        (rst),
        .fft_valid  (fft_valid),
        .fft_bus    (fft_bus),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .frame_done (frame_done),
        .peak_freq  (peak_freq),
        .drop_cnt   (drop_cnt)
    );

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] dat;
    } word_t;

    int          n_cmp = 0;
    int          n_err = 0;
    word_t       exp_q[$];
    logic [3:0]  pk_q[$];
    logic [31:0] fr [16];

    function automatic longint mag(input logic [31:0] w);
        longint r, i;
        r = longint'($signed(w[31:16]));
        i = longint'($signed(w[15:0]));
`ifdef FAS_PEAK_SQMAG_EN
        return r*r + i*i;
`else
        return (r < 0 ? -r : r) + (i < 0 ? -i : i);
`endif
    endfunction

    function automatic logic [3:0] model_peak();
        longint m;
        logic [3:0] p;
        m = 0;
        p = 4'd0;
        for (int k = 0; k < 16; k++) begin
            if (k == 0 || mag(fr[k]) > m) begin
                m = mag(fr[k]);
                p = 4'(k);
            end
        end
        return p;
    endfunction

    task automatic push_frame();
        for (int k = 0; k < 16; k++) exp_q.push_back({4'(k), fr[k]});
        pk_q.push_back(model_peak());
    endtask

    task automatic load_bus();
        for (int k = 0; k < 16; k++) fft_bus[k*32 +: 32] = fr[k];
    endtask

    task automatic send_frame(input bit push);
        load_bus();
        if (push) push_frame();
        fft_valid = 1'b1;
        @(posedge clk); #1;
        fft_valid = 1'b0;
    endtask

    // Scoreboard monitor: handshakes, stall stability and peak reports.
    logic        stall_prev = 1'b0;
    logic [31:0] stall_dat;
    logic [3:0]  stall_idx;

    always @(negedge clk) begin
        word_t w;
        logic [3:0] p;
        if (rst) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== stall_dat || out_idx !== stall_idx) begin
                    n_err++;
                    $display("FAIL stall_hold: valid=%b idx=%0d data=%h, required valid=1 idx=%0d data=%h",
                             out_valid, out_idx, out_data, stall_idx, stall_dat);
                end
            end
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL word_unexpected: idx=%0d data=%h, required none", out_idx, out_data);
                end else begin
                    w = exp_q.pop_front();
                    if ({out_idx, out_data} !== w) begin
                        n_err++;
                        $display("FAIL word: idx=%0d data=%h, required idx=%0d data=%h",
                                 out_idx, out_data, w.idx, w.dat);
                    end
                end
            end
            if (frame_done === 1'b1) begin
                n_cmp++;
                if (pk_q.size() == 0) begin
                    n_err++;
                    $display("FAIL done_unexpected: peak=%0d, required no frame_done", peak_freq);
                end else begin
                    p = pk_q.pop_front();
                    if (peak_freq !== p) begin
                        n_err++;
                        $display("FAIL peak: got %0d, required %0d", peak_freq, p);
                    end
                end
            end
            stall_prev <= out_valid && !out_ready;
            stall_dat  <= out_data;
            stall_idx  <= out_idx;
        end
    end

    task automatic test_reset();
        rst = 1'b1; fft_valid = 1'b0; out_ready = 1'b1; fft_bus = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_idx !== 4'd0 ||
            frame_done !== 1'b0 || peak_freq !== 4'd0 || drop_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_state: valid=%b data=%h idx=%0d done=%b peak=%0d drop=%0d, required all 0",
                     out_valid, out_data, out_idx, frame_done, peak_freq, drop_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        int cyc;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) fr[k] = {16'(k*16), 16'h0};
        send_frame(1'b1);
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b1 || out_idx !== 4'd0) begin
            n_err++;
            $display("FAIL single_latency: valid=%b idx=%0d, required valid=1 idx=0", out_valid, out_idx);
        end
        cyc = 1;
        while (frame_done !== 1'b1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc != 17) begin
            n_err++;
            $display("FAIL single_done_cycle: got %0d, required 17", cyc);
        end
        n_cmp++;
        if (peak_freq !== 4'd15) begin
            n_err++;
            $display("FAIL single_peak: got %0d, required 15", peak_freq);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        logic [3:0] pat;
        int c;
        pat = 4'b1001;
        for (int k = 0; k < 16; k++) fr[k] = 32'h0001_0001;
        fr[3] = {16'h0400, 16'hFC00};
        out_ready = 1'b1;
        send_frame(1'b1);
        c = 0;
        while (frame_done !== 1'b1 && c < 200) begin
            out_ready = pat[c % 4];
            @(posedge clk); #1;
            c++;
        end
        out_ready = 1'b1;
        n_cmp++;
        if (frame_done !== 1'b1 || peak_freq !== 4'd3) begin
            n_err++;
            $display("FAIL bp_peak: done=%b peak=%0d, required done=1 peak=3", frame_done, peak_freq);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ties();
        int c;
        for (int k = 0; k < 16; k++) fr[k] = 32'h0;
        fr[2] = {16'h8000, 16'h0000};
        fr[9] = {16'h0000, 16'h8000};
        send_frame(1'b1);
        c = 0;
        while (frame_done !== 1'b1 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        n_cmp++;
        if (frame_done !== 1'b1 || peak_freq !== 4'd2) begin
            n_err++;
            $display("FAIL ties_peak: done=%b peak=%0d, required done=1 peak=2", frame_done, peak_freq);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overlap();
        int c;
        for (int k = 0; k < 16; k++) fr[k] = {16'(k*3 - 20), 16'(k*100)};
        send_frame(1'b1);
        c = 0;
        while (out_idx !== 4'd5 && c < 50) begin @(posedge clk); #1; c++; end
        for (int k = 0; k < 16; k++) fr[k] = 32'h7FFF_7FFF;
        send_frame(1'b0);
        c = 0;
        while (out_idx !== 4'd15 && c < 50) begin @(posedge clk); #1; c++; end
        for (int k = 0; k < 16; k++) fr[k] = {16'(k*7), 16'(16'hF000 + k)};
        send_frame(1'b1);
        @(negedge clk);
        n_cmp++;
        if (frame_done !== 1'b1 || out_valid !== 1'b1 || out_idx !== 4'd0 || out_data !== fr[0]) begin
            n_err++;
            $display("FAIL overlap_restart: done=%b valid=%b idx=%0d data=%h, required done=1 valid=1 idx=0 data=%h",
                     frame_done, out_valid, out_idx, out_data, fr[0]);
        end
        c = 0;
        @(posedge clk); #1;
        while (frame_done !== 1'b1 && c < 100) begin @(posedge clk); #1; c++; end
        n_cmp++;
        if (frame_done !== 1'b1 || drop_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL overlap_drop: done=%b drop=%0d, required done=1 drop=1", frame_done, drop_cnt);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int c;
        for (int k = 0; k < 16; k++) fr[k] = {16'(k), 16'(16 - k)};
        send_frame(1'b1);
        c = 0;
        while (out_idx !== 4'd7 && c < 50) begin @(posedge clk); #1; c++; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        pk_q.delete();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0 || peak_freq !== 4'd0 || drop_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_mid: valid=%b done=%b peak=%0d drop=%0d, required all 0",
                     out_valid, frame_done, peak_freq, drop_cnt);
        end
        @(posedge clk); #1;
        for (int k = 0; k < 16; k++) fr[k] = {16'(100 - k*5), 16'hFFF0};
        send_frame(1'b1);
        c = 0;
        while (frame_done !== 1'b1 && c < 100) begin @(posedge clk); #1; c++; end
        n_cmp++;
        if (frame_done !== 1'b1 || peak_freq !== 4'd0) begin
            n_err++;
            $display("FAIL reset_mid_after: done=%b peak=%0d, required done=1 peak=0", frame_done, peak_freq);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        int c;
        out_ready = 1'b0;
        for (int k = 0; k < 16; k++) fr[k] = {16'(k*2), 16'(k)};
        load_bus();
        push_frame();
        fft_valid = 1'b1;
        repeat (300) @(posedge clk);
        #1 fft_valid = 1'b0;
        n_cmp++;
        if (drop_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL sat_count: got %0d, required 255", drop_cnt);
        end
        fft_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1 fft_valid = 1'b0;
        n_cmp++;
        if (drop_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL sat_hold: got %0d, required 255", drop_cnt);
        end
        out_ready = 1'b1;
        c = 0;
        while (frame_done !== 1'b1 && c < 100) begin @(posedge clk); #1; c++; end
        n_cmp++;
        if (frame_done !== 1'b1 || peak_freq !== 4'd15) begin
            n_err++;
            $display("FAIL sat_drain: done=%b peak=%0d, required done=1 peak=15", frame_done, peak_freq);
        end
        repeat (2) @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_ties();
        test_overlap();
        test_reset_mid();
        test_saturation();
        n_cmp++;
        if (exp_q.size() != 0 || pk_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: words=%0d peaks=%0d left, required 0 and 0",
                     exp_q.size(), pk_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
